// File: rtl/ioctl_pkg.sv
// Shared types and widths for the ioctl download loader.
package ioctl_pkg;

    localparam int unsigned ADDR_W  = 25;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned DLY_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_TAIL
    } state_e;

    // Address/data pair presented on the ioctl write port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/loader_delay_cnt.sv
// Loadable down-counter that times the LEAD, GAP and TAIL phases of the loader.
module loader_delay_cnt
    import ioctl_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    output logic             expired_c
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // Saturates at zero so a phase can be stretched without reloading.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DLY_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/ioctl_loader.sv
// Streams a counted block of source bytes onto an ioctl download port,
// framing it with lead/tail windows and a minimum gap between writes.
module ioctl_loader
    import ioctl_pkg::*;
#(
    parameter int unsigned LEAD_CYC = 4,
    parameter int unsigned GAP_CYC  = 3,
    parameter int unsigned TAIL_CYC = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               start,
    input  logic [INDEX_W-1:0] index_in,
    input  logic [ADDR_W-1:0]  length,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               src_ready,
    output logic               ioctl_download,
    output logic [INDEX_W-1:0] ioctl_index,
    output logic               ioctl_wr,
    output logic [ADDR_W-1:0]  ioctl_addr,
    output logic [DATA_W-1:0]  ioctl_dout,
    input  logic               ioctl_wait,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    beat_t                beat_q, beat_d;
    logic                 download_q, download_d;
    logic                 wr_q, wr_d;
    logic                 dly_load;
    logic [DLY_W-1:0]     dly_val;
    logic                 dly_expired;

    loader_delay_cnt u_delay (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .load      (dly_load),
        .load_val  (dly_val),
        .expired_c (dly_expired)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        beat_d    = beat_q;
        dly_load  = 1'b0;
        dly_val   = '0;
        src_ready = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LEAD;
                    len_d    = length;
                    index_d  = index_in;
                    cnt_d    = '0;
                    dly_load = 1'b1;
                    dly_val  = DLY_W'(LEAD_CYC - 1);
                end
            end
            ST_LEAD: begin
                if (dly_expired) begin
                    if (len_q == '0) begin
                        state_d  = ST_TAIL;
                        dly_load = 1'b1;
                        dly_val  = DLY_W'(TAIL_CYC - 1);
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                src_ready = ~ioctl_wait;
                if (src_valid && !ioctl_wait) begin
                    beat_d  = '{addr: cnt_q, data: src_data};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d  = ST_GAP;
                dly_load = 1'b1;
                dly_val  = DLY_W'(GAP_CYC - 1);
            end
            // Gap is held open while the receiver back-pressures.
            ST_GAP: begin
                if (dly_expired && !ioctl_wait) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_d == len_q) begin
                        state_d  = ST_TAIL;
                        dly_load = 1'b1;
                        dly_val  = DLY_W'(TAIL_CYC - 1);
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_TAIL: begin
                if (dly_expired) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        download_d = (state_d != ST_IDLE);
        wr_d       = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            index_q    <= '0;
            beat_q     <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            index_q    <= index_d;
            beat_q     <= beat_d;
            download_q <= download_d;
            wr_q       <= wr_d;
        end
    end

    assign ioctl_download = download_q;
    assign busy           = download_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_index    = index_q;
    assign ioctl_addr     = beat_q.addr;
    assign ioctl_dout     = beat_q.data;

endmodule

// File: tb/tb_ioctl_loader.sv
// Scenario bench for ioctl_loader: a per-cycle monitor scores every write
// against the source byte stream; each scenario task judges the results.
module tb_ioctl_loader;

    localparam int LEAD = 4;
    localparam int GAP  = 3;
    localparam int TAIL = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  index_in;
    logic [24:0] length;
    logic        src_valid;
    logic [7:0]  src_data;
    logic        src_ready;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        busy;
    logic        done;

    always #5 clk_sys = ~clk_sys;

    ioctl_loader #(.LEAD_CYC(LEAD), .GAP_CYC(GAP), .TAIL_CYC(TAIL)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .start          (start),
        .index_in       (index_in),
        .length         (length),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .done           (done)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Monitor / scoreboard state
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_idx;
    int wr_cyc_q[$];
    int wr_n, wr_err, gap_err, wait_err, idx_err, done_n, done_err, hold_err;
    int dl_n, accepted, first_wr_dl, last_wr_dl;
    bit wait_prev, done_prev, hold_chk;

    task automatic clear_mon();
        wr_cyc_q.delete();
        wr_n = 0; wr_err = 0; gap_err = 0; wait_err = 0; idx_err = 0;
        done_n = 0; done_err = 0; hold_err = 0; dl_n = 0; accepted = 0;
        first_wr_dl = -1; last_wr_dl = -1;
        wait_prev = 1'b0; done_prev = 1'b0; hold_chk = 1'b0;
    endtask

    // One clock: drive inputs, sample settled outputs mid-cycle, advance.
    task automatic run_cycle(input bit st, input bit v, input bit w);
        start      = st;
        ioctl_wait = w;
        src_valid  = v && (accepted < exp_bytes.size());
        src_data   = src_valid ? exp_bytes[accepted] : 8'($urandom);
        #2;
        if (src_valid && src_ready) accepted++;
        if (ioctl_download) begin
            dl_n++;
            if (ioctl_index !== exp_idx) idx_err++;
        end
        if (hold_chk && (ioctl_addr !== 25'd1 || ioctl_dout !== exp_bytes[1])) hold_err++;
        if (ioctl_wr) begin
            if (wait_prev) wait_err++;
            if (wr_n >= exp_bytes.size()) wr_err++;
            else if (ioctl_addr !== 25'(wr_n) || ioctl_dout !== exp_bytes[wr_n]) wr_err++;
            if (wr_cyc_q.size() > 0 && (cyc - wr_cyc_q[$] - 1) < GAP) gap_err++;
            if (wr_n == 0) first_wr_dl = dl_n - 1;
            last_wr_dl = dl_n - 1;
            wr_cyc_q.push_back(cyc);
            wr_n++;
        end
        if (done_prev && ioctl_download) done_err++;
        if (done) begin
            done_n++;
            if (!ioctl_download) done_err++;
        end
        done_prev = done;
        wait_prev = w;
        cyc++;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic fill_bytes(input int n);
        exp_bytes.delete();
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
    endtask

    task automatic begin_dl(input logic [24:0] len, input logic [7:0] idx);
        length   = len;
        index_in = idx;
        exp_idx  = idx;
        clear_mon();
        run_cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic finish_dl(input int budget);
        for (int k = 0; k < budget && done_n == 0; k++) run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
        ioctl_wait = 1'b0; index_in = 8'hFF; length = 25'd7;
        #12;
        n_cmp++; if ({ioctl_download, ioctl_wr, src_ready, busy, done} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ioctl_download, ioctl_wr, src_ready, busy, done}); end
        n_cmp++; if (ioctl_addr !== 25'd0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", ioctl_addr); end
        n_cmp++; if ({ioctl_dout, ioctl_index} !== 16'h0) begin n_fail++; $display("FAIL reset_data_index: got %h want 0000", {ioctl_dout, ioctl_index}); end
        @(negedge clk_sys);
        reset = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_basic();
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        begin_dl(25'd4, 8'h00);
        finish_dl(200);
        n_cmp++; if (wr_n !== 4) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 4", wr_n); end
        n_cmp++; if (wr_err !== 0) begin n_fail++; $display("FAIL basic_addr_data: got %0d bad writes want 0", wr_err); end
        n_cmp++; if (gap_err !== 0) begin n_fail++; $display("FAIL basic_gap: got %0d short gaps want 0", gap_err); end
        n_cmp++; if (first_wr_dl !== LEAD + 1) begin n_fail++; $display("FAIL basic_lead: got first wr at %0d want %0d", first_wr_dl, LEAD + 1); end
        n_cmp++; if (dl_n - 1 - last_wr_dl !== GAP + TAIL) begin n_fail++; $display("FAIL basic_tail: got %0d want %0d", dl_n - 1 - last_wr_dl, GAP + TAIL); end
        n_cmp++; if (dl_n !== LEAD + 4 * (GAP + 2) + TAIL) begin n_fail++; $display("FAIL basic_window: got %0d want %0d", dl_n, LEAD + 4 * (GAP + 2) + TAIL); end
        n_cmp++; if (done_n !== 1 || done_err !== 0) begin n_fail++; $display("FAIL basic_done: got %0d pulses %0d misplaced want 1/0", done_n, done_err); end
    endtask

    task automatic test_zero_len();
        exp_bytes.delete();
        begin_dl(25'd0, 8'h3C);
        finish_dl(100);
        n_cmp++; if (dl_n !== LEAD + TAIL) begin n_fail++; $display("FAIL zero_window: got %0d want %0d", dl_n, LEAD + TAIL); end
        n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL zero_wr: got %0d want 0", wr_n); end
        n_cmp++; if (done_n !== 1 || done_err !== 0) begin n_fail++; $display("FAIL zero_done: got %0d pulses %0d misplaced want 1/0", done_n, done_err); end
        n_cmp++; if (idx_err !== 0) begin n_fail++; $display("FAIL zero_index: got %0d bad cycles want 0", idx_err); end
    endtask

    task automatic test_wait_gap();
        int waits = 0;
        fill_bytes(3);
        begin_dl(25'd3, 8'h81);
        for (int k = 0; k < 300 && done_n == 0; k++) begin
            bit w = 1'b0;
            if (wr_n >= 2 && waits < 10) begin w = 1'b1; waits++; end
            hold_chk = w;
            run_cycle(1'b0, 1'b1, w);
        end
        hold_chk = 1'b0;
        finish_dl(50);
        n_cmp++; if (wr_n !== 3 || wr_err !== 0) begin n_fail++; $display("FAIL wait_writes: got %0d writes %0d bad want 3/0", wr_n, wr_err); end
        n_cmp++; if (wait_err !== 0) begin n_fail++; $display("FAIL wait_blocked: got %0d wr after wait want 0", wait_err); end
        n_cmp++; if (hold_err !== 0) begin n_fail++; $display("FAIL wait_hold: got %0d cycles addr/data moved want 0", hold_err); end
        n_cmp++; if (wr_n == 3 && wr_cyc_q[2] - wr_cyc_q[1] <= 10) begin n_fail++; $display("FAIL wait_third_late: got spacing %0d want >10", wr_cyc_q[2] - wr_cyc_q[1]); end
    endtask

    task automatic test_src_stall();
        int stall = 0;
        fill_bytes(3);
        begin_dl(25'd3, 8'h42);
        for (int k = 0; k < 300 && done_n == 0; k++) begin
            bit v = 1'b1;
            if (wr_n == 1 && stall < 20) begin v = 1'b0; stall++; end
            run_cycle(1'b0, v, 1'b0);
        end
        finish_dl(50);
        n_cmp++; if (wr_n !== 3 || wr_err !== 0) begin n_fail++; $display("FAIL stall_writes: got %0d writes %0d bad want 3/0", wr_n, wr_err); end
        n_cmp++; if (accepted !== 3) begin n_fail++; $display("FAIL stall_accepted: got %0d want 3", accepted); end
        n_cmp++; if (wr_n == 3 && wr_cyc_q[1] - wr_cyc_q[0] <= 20) begin n_fail++; $display("FAIL stall_spacing: got %0d want >20", wr_cyc_q[1] - wr_cyc_q[0]); end
    endtask

    task automatic test_reset_mid();
        fill_bytes(8);
        begin_dl(25'd8, 8'h5A);
        for (int k = 0; k < 200 && wr_n < 2; k++) run_cycle(1'b0, 1'b1, 1'b0);
        n_cmp++; if (wr_n !== 2) begin n_fail++; $display("FAIL rstmid_prewrites: got %0d want 2", wr_n); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({ioctl_download, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async: got %b want 000", {ioctl_download, busy, done}); end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        clear_mon();
        for (int k = 0; k < 12; k++) run_cycle(1'b0, 1'b1, 1'b0);
        n_cmp++; if (dl_n !== 0 || wr_n !== 0 || done_n !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got dl %0d wr %0d done %0d want 0/0/0", dl_n, wr_n, done_n); end
        fill_bytes(2);
        begin_dl(25'd2, 8'hC3);
        finish_dl(200);
        n_cmp++; if (wr_n !== 2 || wr_err !== 0) begin n_fail++; $display("FAIL rstmid_fresh: got %0d writes %0d bad want 2/0", wr_n, wr_err); end
        n_cmp++; if (done_n !== 1) begin n_fail++; $display("FAIL rstmid_done: got %0d want 1", done_n); end
    endtask

    task automatic test_restart_ignored();
        bit poked = 1'b0;
        fill_bytes(5);
        begin_dl(25'd5, 8'hA7);
        for (int k = 0; k < 300 && done_n == 0; k++) begin
            if (wr_n == 2 && !poked) begin
                length = 25'd2; index_in = 8'h1E; poked = 1'b1;
                run_cycle(1'b1, 1'b1, 1'b0);
            end else begin
                run_cycle(1'b0, 1'b1, 1'b0);
            end
        end
        finish_dl(50);
        n_cmp++; if (wr_n !== 5 || wr_err !== 0) begin n_fail++; $display("FAIL restart_writes: got %0d writes %0d bad want 5/0", wr_n, wr_err); end
        n_cmp++; if (idx_err !== 0) begin n_fail++; $display("FAIL restart_index: got %0d bad cycles want 0", idx_err); end
        n_cmp++; if (done_n !== 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", done_n); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len = $urandom_range(0, 12);
            int vp  = $urandom_range(30, 100);
            int wp  = $urandom_range(0, 40);
            fill_bytes(len);
            begin_dl(25'(len), 8'($urandom));
            for (int k = 0; k < 3000 && done_n == 0; k++)
                run_cycle(1'b0, $urandom_range(0, 99) < vp, $urandom_range(0, 99) < wp);
            finish_dl(50);
            n_cmp++; if (wr_n !== len || wr_err !== 0) begin n_fail++; $display("FAIL rand%0d_writes: got %0d writes %0d bad want %0d/0", it, wr_n, wr_err, len); end
            n_cmp++; if (accepted !== len) begin n_fail++; $display("FAIL rand%0d_accepted: got %0d want %0d", it, accepted, len); end
            n_cmp++; if (gap_err + wait_err + idx_err + done_err !== 0) begin n_fail++; $display("FAIL rand%0d_protocol: gap %0d wait %0d idx %0d done %0d want all 0", it, gap_err, wait_err, idx_err, done_err); end
            n_cmp++; if (done_n !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", it, done_n); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_zero_len();
        test_wait_gap();
        test_src_stall();
        test_reset_mid();
        test_restart_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 Parameter LEAD_CYC, default 4: cycles ioctl_download is high before the first write.
REQ-002 Parameter GAP_CYC, default 3: minimum idle cycles after each ioctl_wr pulse.
REQ-003 Parameter TAIL_CYC, default 4: cycles ioctl_download stays high after the last write.
REQ-004 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a download; honoured only in IDLE.
REQ-007 index_in  in  8  ioctl index latched at start.
REQ-008 length  in  25  byte count latched at start.
REQ-009 src_valid / src_data  in  1 / 8  byte source, valid/ready handshake.
REQ-010 src_ready  out  1  loader accepts src_data this cycle.
REQ-011 ioctl_download  out  1  download window active.
REQ-012 ioctl_index  out  8  latched index, stable for the whole window.
REQ-013 ioctl_wr  out  1  one-cycle write strobe.
REQ-014 ioctl_addr / ioctl_dout  out  25 / 8  address and data of current write.
REQ-015 ioctl_wait  in  1  receiver back-pressure; high blocks new writes.
REQ-016 busy / done  out  1 / 1  busy: not IDLE; done: one-cycle pulse at end of window.

Function
REQ-017 FSM states: IDLE, LEAD, FETCH, WRITE, GAP, TAIL; DONE is not a state (done pulse is combinational on TAIL exit).
REQ-018 IDLE -> LEAD on start; latch index_in, length; clear byte counter; ioctl_download rises the cycle after start.
REQ-019 LEAD lasts exactly LEAD_CYC cycles, then -> FETCH, or -> TAIL if latched length is 0.
REQ-020 FETCH: src_ready = ~ioctl_wait; on src_valid & src_ready capture src_data into ioctl_dout, set ioctl_addr = counter, -> WRITE.
REQ-021 WRITE: ioctl_wr high exactly one cycle; ioctl_addr/ioctl_dout stable from WRITE through end of GAP.
REQ-022 GAP: at least GAP_CYC cycles; extends while ioctl_wait high; counter increments on GAP exit.
REQ-023 GAP exit -> TAIL when incremented counter equals length, else -> FETCH.
REQ-024 TAIL lasts TAIL_CYC cycles; ioctl_download falls on exit to IDLE, done pulses that same cycle.
REQ-025 src_ready low in every state except FETCH; source bytes never dropped or duplicated.
REQ-026 ioctl_wait high in FETCH stalls indefinitely without issuing ioctl_wr.
REQ-027 start while busy is ignored; no re-latch of index or length.
REQ-028 Counter 25 bits; length up to 2^25-1; no wrap within one download.
REQ-029 ioctl_addr bytes are sequential from 0 with no gaps.

Reset
REQ-030 Reset asynchronous: state IDLE, counters 0, ioctl_download/ioctl_wr/src_ready/busy/done 0, ioctl_addr/ioctl_dout/ioctl_index 0.
REQ-031 Reset mid-download aborts immediately: ioctl_download drops with reset, no done pulse, no further writes.
REQ-032 After reset release the next start begins a fresh download at address 0.

Structure
REQ-033 Shared package ioctl_pkg: FSM state enum, ioctl address width constant (25), data width constant (8).
REQ-034 One sub-module natural: loader_delay_cnt, a loadable down-counter reused for LEAD, GAP and TAIL timing.
REQ-035 No memories; source buffering lives outside the block.

Verification
REQ-036 length=4, index_in=0, src always valid with 0x11,0x22,0x33,0x44, wait low -> four ioctl_wr pulses at addr 0..3 with those data, ≥GAP_CYC idle cycles between, one done pulse.
REQ-037 length=0, start -> ioctl_download high LEAD_CYC+TAIL_CYC cycles, zero ioctl_wr, done pulses once.
REQ-038 length=3, ioctl_wait held high 10 cycles during second GAP -> no wr during wait, addr 1 data held, third write at addr 2 after wait falls.
REQ-039 length=3, src_valid low for 20 cycles before byte 1 -> loader waits in FETCH, addresses 0,1,2 still contiguous, no duplicated byte.
REQ-040 Reset asserted after second write of length=8 -> ioctl_download low asynchronously, no done; new start with length=2 writes addr 0,1.
REQ-041 start pulsed again mid-download with different length/index -> ignored; original length and ioctl_index honoured.
